// File: rtl/mat_scan_pwm.sv
// mat_scan_pwm: row-scanning driver for a red/green LED dot matrix with a scan
// prescaler, double-buffered frames and per-frame PWM brightness.
module mat_scan_pwm #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int DIV      = 4,
   parameter int PWM_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ROWS*COLS-1:0] frame_red,
   input  logic [ROWS*COLS-1:0] frame_green,
   input  logic                 frame_load,
   input  logic [PWM_BITS-1:0]  brightness,
   output logic                 load_ack,
   output logic                 frame_start,
   output logic [COLS-1:0]      red_led,
   output logic [COLS-1:0]      green_led,
   output logic [ROWS-1:0]      GND
);
   localparam int PIX   = ROWS * COLS;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int ROW_W = $clog2(ROWS);
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [PWM_BITS-1:0] PH_LAST  = '1;

   logic [PRE_W-1:0]    pre;
   logic [PWM_BITS-1:0] ph;
   logic [ROW_W-1:0]    row;
   logic [PWM_BITS-1:0] bright_q;
   logic [PIX-1:0]      sh_red, sh_green, act_red, act_green;
   logic                pending;

   logic                tick, last_ph, swap, en;
   logic [ROWS-1:0]     gnd_d;
   logic [COLS-1:0]     red_d, green_d;

   assign tick    = (pre == PRE_LAST);
   assign last_ph = (ph == PH_LAST);
   assign swap    = tick && last_ph && (row == ROW_LAST);
   // The last phase of every slot stays dark so the row sink can turn off
   // before the next row's columns are driven.
   assign en      = (ph < bright_q) && !last_ph;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         ph  <= '0;
         row <= '0;
      end else begin
         // NOTE: state updates use <= so every process samples pre-edge values.
         pre <= tick ? '0 : pre + PRE_W'(1);
         if (tick) begin
            ph <= last_ph ? '0 : ph + PWM_BITS'(1);
            if (last_ph)
               row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the frame buffers are plain flops; resetting them blanks the
         // display and drops any queued frame.
         sh_red    <= '0;
         sh_green  <= '0;
         act_red   <= '0;
         act_green <= '0;
         pending   <= 1'b0;
         bright_q  <= '0;
      end else begin
         if (frame_load) begin
            sh_red   <= frame_red;
            sh_green <= frame_green;
         end
         // A load on the swap edge copies the old shadow here and leaves the
         // new data pending for the next frame.
         if (swap) begin
            bright_q <= brightness;
            if (pending) begin
               act_red   <= sh_red;
               act_green <= sh_green;
            end
         end
         if (frame_load)
            pending <= 1'b1;
         else if (swap)
            pending <= 1'b0;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      gnd_d   = '1;
      red_d   = '0;
      green_d = '0;
      if (en) begin
         gnd_d[row] = 1'b0;
         red_d      = act_red[int'(row) * COLS +: COLS];
         green_d    = act_green[int'(row) * COLS +: COLS];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         GND         <= '1;
         red_led     <= '0;
         green_led   <= '0;
         load_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         GND         <= gnd_d;
         red_led     <= red_d;
         green_led   <= green_d;
         load_ack    <= swap && pending;
         frame_start <= swap;
      end
   end

endmodule

// File: tb/tb_mat_scan_pwm.sv
// Scoreboard bench for mat_scan_pwm: a default 8x8 instance checked per frame
// and a 5x3 instance checked cycle by cycle.
module tb_mat_scan_pwm;
   localparam int ROWS = 8;
   localparam int COLS = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] frame_red, frame_green;
   logic        frame_load;
   logic [2:0]  brightness;
   logic        load_ack, frame_start;
   logic [7:0]  red_led, green_led, gnd;

   logic [14:0] s_red, s_green;
   logic        s_load;
   logic [0:0]  s_bright;
   logic        s_ack, s_fs;
   logic [2:0]  s_red_led, s_green_led;
   logic [4:0]  s_gnd;

   mat_scan_pwm dut (
      .clk(clk), .rst_n(rst_n), .frame_red(frame_red), .frame_green(frame_green),
      .frame_load(frame_load), .brightness(brightness), .load_ack(load_ack),
      .frame_start(frame_start), .red_led(red_led), .green_led(green_led), .GND(gnd)
   );

   mat_scan_pwm #(.ROWS(5), .COLS(3), .DIV(1), .PWM_BITS(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .frame_red(s_red), .frame_green(s_green),
      .frame_load(s_load), .brightness(s_bright), .load_ack(s_ack),
      .frame_start(s_fs), .red_led(s_red_led), .green_led(s_green_led), .GND(s_gnd)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Edge counter since the last reset release; edge 1 is the first rising edge.
   int cyc = 0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic at_edge(input int n);
      while (cyc < n - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_at(input int n, input logic [63:0] r, input logic [63:0] g);
      at_edge(n);
      frame_red   = r;
      frame_green = g;
      frame_load  = 1'b1;
      @(posedge clk);
      #1;
      frame_load = 1'b0;
   endtask

   // ---------------- default instance: per-frame scoreboard ----------------
   typedef struct {
      string       tag;
      logic        ack;
      int          on_clks;
      logic [63:0] red;
      logic [63:0] green;
   } frame_exp_t;
   frame_exp_t exp_q[$];

   function automatic void push_frame(input string tag, input logic ack, input int on_clks,
                                      input logic [63:0] r, input logic [63:0] g);
      frame_exp_t e;
      e.tag = tag; e.ack = ack; e.on_clks = on_clks; e.red = r; e.green = g;
      exp_q.push_back(e);
   endfunction

   int         on_cnt     [ROWS];
   logic [7:0] red_seen   [ROWS];
   logic [7:0] green_seen [ROWS];
   int         bad_gnd, stray_led, stray_ack;

   function automatic void clear_acc();
      for (int r = 0; r < ROWS; r++) begin
         on_cnt[r] = 0; red_seen[r] = '0; green_seen[r] = '0;
      end
      bad_gnd = 0; stray_led = 0; stray_ack = 0;
   endfunction

   always @(negedge clk) begin
      frame_exp_t e;
      if (!rst_n) clear_acc();
      else begin
         if (gnd != 8'hFF) begin
            if ($countones(~gnd) != 1) bad_gnd++;
            else for (int r = 0; r < ROWS; r++)
               if (!gnd[r]) begin
                  on_cnt[r]++;
                  red_seen[r]   |= red_led;
                  green_seen[r] |= green_led;
               end
         end else if ((red_led | green_led) != 8'h00) stray_led++;
         if (load_ack && !frame_start) stray_ack++;
         if (frame_start) begin
            if (exp_q.size() == 0) check("unexpected frame_start", 1'b1, 1'b0);
            else begin
               e = exp_q.pop_front();
               check({e.tag, " load_ack"}, load_ack, e.ack);
               for (int r = 0; r < ROWS; r++) begin
                  check($sformatf("%s row%0d on_clks", e.tag, r), on_cnt[r], e.on_clks);
                  check($sformatf("%s row%0d red", e.tag, r), red_seen[r], e.red[8*r +: 8]);
                  check($sformatf("%s row%0d green", e.tag, r), green_seen[r], e.green[8*r +: 8]);
               end
               check({e.tag, " multi-row GND"}, bad_gnd, 0);
               check({e.tag, " leds while blank"}, stray_led, 0);
               check({e.tag, " stray load_ack"}, stray_ack, 0);
            end
            clear_acc();
         end
      end
   end

   // ---------------- small instance: per-cycle scoreboard ----------------
   typedef struct {
      logic       ack;
      logic [4:0] gnd;
      logic [2:0] red;
      logic [2:0] green;
   } small_exp_t;
   small_exp_t sexp_q[$];

   logic [2:0] s_rrow [5] = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b101};
   logic [2:0] s_grow [5] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b011};
   logic [4:0] s_gtab [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

   int s_left = 0;
   always @(negedge clk) begin
      small_exp_t se;
      if (!rst_n) s_left = 0;
      else begin
         if (s_left == 0 && s_fs && sexp_q.size() != 0) s_left = 10;
         if (s_left > 0 && sexp_q.size() != 0) begin
            se = sexp_q.pop_front();
            check($sformatf("small t%0d GND", 10 - s_left), s_gnd, se.gnd);
            check($sformatf("small t%0d red", 10 - s_left), s_red_led, se.red);
            check($sformatf("small t%0d green", 10 - s_left), s_green_led, se.green);
            check($sformatf("small t%0d load_ack", 10 - s_left), s_ack, se.ack);
            s_left--;
         end
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [63:0] A_RED   = 64'h8100_0000_0000_0001;
   localparam logic [63:0] X_RED   = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] Y_RED   = 64'h0102_0408_1020_4080;
   localparam logic [63:0] W_GREEN = 64'h1122_3344_5566_7788;
   localparam logic [63:0] Z_RED   = 64'hAA55_AA55_AA55_AA55;
   localparam logic [63:0] Z_GREEN = 64'h0F0F_0F0F_0F0F_0F0F;

   initial begin
      small_exp_t se;
      frame_red = '0; frame_green = '0; frame_load = 1'b0; brightness = 3'd7;
      s_red = '0; s_green = '0; s_load = 1'b0; s_bright = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("reset GND", gnd, 8'hFF);
      check("reset red_led", red_led, 8'h00);
      check("reset green_led", green_led, 8'h00);
      check("reset load_ack", load_ack, 1'b0);
      check("reset frame_start", frame_start, 1'b0);
      check("reset small GND", s_gnd, 5'h1F);

      // Small instance: two scanned frames of the same picture, ack only on the first.
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 10; i++) begin
            se.ack = (i == 0) && (w == 0);
            if (i % 2 == 0) begin
               se.gnd = 5'h1F; se.red = 3'b000; se.green = 3'b000;
            end else begin
               se.gnd = s_gtab[i/2]; se.red = s_rrow[i/2]; se.green = s_grow[i/2];
            end
            sexp_q.push_back(se);
         end

      push_frame("f0 dark after reset", 1'b1, 0, '0, '0);
      push_frame("f1 A bright7", 1'b0, 28, A_RED, '0);
      @(negedge clk);
      rst_n = 1'b1;

      at_edge(3);
      s_red = 15'b101_111_100_010_001; s_green = 15'b011_000_000_000_100; s_load = 1'b1;
      @(posedge clk);
      #1;
      s_load = 1'b0;

      load_at(5, A_RED, '0);
      at_edge(300);
      brightness = 3'd2;
      push_frame("f2 A bright2", 1'b1, 8, A_RED, '0);

      load_at(522, X_RED, X_RED);
      load_at(532, Y_RED, '0);
      at_edge(600);
      brightness = 3'd5;
      push_frame("f3 Y double-load", 1'b1, 20, Y_RED, '0);
      push_frame("f4 W swapped on load edge", 1'b1, 20, '0, W_GREEN);
      push_frame("f5 Z one frame later", 1'b0, 20, Z_RED, Z_GREEN);

      load_at(800, '0, W_GREEN);
      load_at(1024, Z_RED, Z_GREEN);
      at_edge(1300);
      brightness = 3'd0;
      push_frame("f6 bright0", 1'b0, 0, '0, '0);
      at_edge(1600);
      brightness = 3'd7;

      load_at(1850, X_RED, X_RED);
      at_edge(1901);
      check("row3 GND before reset", gnd, 8'hF7);
      check("row3 red before reset", red_led, 8'hAA);
      check("row3 green before reset", green_led, 8'h0F);

      #2;
      rst_n = 1'b0;
      #1;
      check("async reset GND", gnd, 8'hFF);
      check("async reset red_led", red_led, 8'h00);
      check("async reset green_led", green_led, 8'h00);
      check("async reset small GND", s_gnd, 5'h1F);

      repeat (3) @(posedge clk);
      push_frame("r0 dark after reset", 1'b0, 0, '0, '0);
      push_frame("r1 active cleared", 1'b0, 28, '0, '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 700 && (exp_q.size() != 0 || sexp_q.size() != 0); i++)
         @(posedge clk);
      check("frame records left", exp_q.size(), 0);
      check("small records left", sexp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
